// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : instr_fetch_queue_if                                             |
// | Brief    : Loader/decode-side bus of the instruction fetch queue.           |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface instr_fetch_queue_if #(
  parameter int unsigned ROM_WORDS   = 256,
  parameter int unsigned QUEUE_DEPTH = 8
);
  logic                           rom_wr_en;
  logic [$clog2(ROM_WORDS)-1:0]   rom_wr_addr;
  logic [31:0]                    rom_wr_data;
  logic [31:0]                    rom_size;
  logic                           run;
  logic                           redirect_valid;
  logic [31:0]                    redirect_pc;
  logic                           instr_ready;
  logic                           instr_valid;
  logic [31:0]                    instruction;
  logic [31:0]                    instr_pc;
  logic [$clog2(QUEUE_DEPTH):0]   occupancy;
  logic                           fetch_complete;

  modport master (
    output rom_wr_en, rom_wr_addr, rom_wr_data, rom_size, run,
           redirect_valid, redirect_pc, instr_ready,
    input  instr_valid, instruction, instr_pc, occupancy, fetch_complete
  );

  modport slave (
    input  rom_wr_en, rom_wr_addr, rom_wr_data, rom_size, run,
           redirect_valid, redirect_pc, instr_ready,
    output instr_valid, instruction, instr_pc, occupancy, fetch_complete
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : instr_fetch_queue                                                |
// | Brief    : Writable instruction ROM, PC sequencer and fetch FIFO to decode. |
// |            Define IFQ_REDIRECT_EN to enable PC redirect with queue flush.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module instr_fetch_queue #(
  parameter int unsigned ROM_WORDS   = 256,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_queue_if.slave bus
);
  localparam int unsigned RW        = $clog2(ROM_WORDS);
  localparam int unsigned PW        = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);
  localparam logic [PW:0] FULL_OCC  = (PW+1)'(QUEUE_DEPTH);

  logic [31:0]   rom_q    [ROM_WORDS];
  logic [31:0]   qinstr_q [QUEUE_DEPTH];
  logic [31:0]   qpc_q    [QUEUE_DEPTH];

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   occ_q, occ_d;

  logic [31:0]   limit;
  logic [31:0]   fetch_word;
  logic [31:0]   redirect_tgt;
  logic          empty, full, deq, fetch_ok, enq, flush;

`ifdef IFQ_REDIRECT_EN
  logic unused_redirect_lsbs;
  assign flush                = bus.redirect_valid;
  assign redirect_tgt         = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
`else
  logic unused_redirect;
  assign flush           = 1'b0;
  assign redirect_tgt    = '0;
  assign unused_redirect = ^{bus.redirect_valid, bus.redirect_pc};
`endif

  // Fetch never runs past the physical ROM, whatever the loader claims.
  assign limit      = (bus.rom_size < ROM_BYTES) ? bus.rom_size : ROM_BYTES;
  assign fetch_word = rom_q[pc_q[RW+1:2]];

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == FULL_OCC);
  assign deq      = ~empty & bus.instr_ready;
  assign fetch_ok = bus.run & (pc_q < limit) & (~full | deq);
  assign enq      = fetch_ok & ~flush;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      // Flush voids any same-cycle handshake: the head is simply dropped.
      pc_d     = redirect_tgt;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (fetch_ok) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + 32'd4;
      end
      occ_d = occ_q + (PW+1)'(fetch_ok) - (PW+1)'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; a same-cycle fetch of a written word sees old data.
  always_ff @(posedge clk) begin
    if (bus.rom_wr_en) begin
      rom_q[bus.rom_wr_addr] <= bus.rom_wr_data;
    end
    if (enq) begin
      qinstr_q[wr_ptr_q] <= fetch_word;
      qpc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign bus.instr_valid    = ~empty;
  assign bus.instruction    = empty ? 32'h0 : qinstr_q[rd_ptr_q];
  assign bus.instr_pc       = empty ? 32'h0 : qpc_q[rd_ptr_q];
  assign bus.occupancy      = occ_q;
  assign bus.fetch_complete = (pc_q >= limit) & empty;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_queue                                             |
// | Brief    : Self-checking bench for instr_fetch_queue.                       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_instr_fetch_queue;
  localparam int unsigned ROM_WORDS = 256;
  localparam int unsigned QD        = 8;
  localparam int unsigned RW        = $clog2(ROM_WORDS);
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.ROM_WORDS(ROM_WORDS), .QUEUE_DEPTH(QD)) bus ();

  instr_fetch_queue #(
    .ROM_WORDS  (ROM_WORDS),
    .QUEUE_DEPTH(QD),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    bit          run;
    bit          ready;
    bit          exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    int          exp_occ;
    bit          exp_fc;
  } vec_t;

  entry_t      mq[$];
  logic [31:0] mrom [ROM_WORDS];
  logic [31:0] mpc;
  logic [31:0] prog [4];
  vec_t        tbl [6];
  logic [31:0] last_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] lim(input logic [31:0] sz);
    return (sz < 32'(ROM_WORDS * 4)) ? sz : 32'(ROM_WORDS * 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
    chk("instruction", bus.instruction, (mq.size() != 0) ? mq[0].instr : 32'h0);
    chk("instr_pc", bus.instr_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("occupancy", 32'(bus.occupancy), 32'(mq.size()));
    chk("fetch_complete", 32'(bus.fetch_complete),
        32'((mpc >= lim(bus.rom_size)) && (mq.size() == 0)));
  endtask

  // Reference: one clock edge expressed as queue operations on the model state.
  task automatic model_step();
    bit     deq;
    bit     flush;
    bit     go;
    entry_t e;
    deq   = (mq.size() != 0) && bus.instr_ready;
    flush = 1'b0;
`ifdef IFQ_REDIRECT_EN
    flush = bus.redirect_valid;
`endif
    if (flush) begin
      mq.delete();
      mpc = bus.redirect_pc & ~32'h3;
    end else begin
      go      = bus.run && (mpc < lim(bus.rom_size)) && ((mq.size() < QD) || deq);
      e.instr = mrom[RW'((mpc >> 2) % ROM_WORDS)];
      e.pc    = mpc;
      if (deq) void'(mq.pop_front());
      if (go) begin
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    if (bus.rom_wr_en) mrom[bus.rom_wr_addr] = bus.rom_wr_data;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic quiet_inputs();
    bus.rom_wr_en      = 1'b0;
    bus.rom_wr_addr    = '0;
    bus.rom_wr_data    = '0;
    bus.run            = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
  endtask

  // Reset asserted between edges, checked while held, released on a falling edge.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    mq.delete();
    mpc = RESET_PC;
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00300113;
    prog[2] = 32'h002081b3;
    prog[3] = 32'h40208233;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00500093, 32'h0, 1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h00300113, 32'h4, 1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h002081b3, 32'h8, 1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h40208233, 32'hc, 1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0, 0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0, 0, 1'b1};

    quiet_inputs();
    bus.rom_size = 32'd16;
    rst_n = 1'b0;
    mpc   = RESET_PC;
    #12;
    check_model();
    chk("rst_fc_size16", 32'(bus.fetch_complete), 32'd0);
    bus.rom_size = 32'd0;
    #1;
    chk("rst_fc_size0", 32'(bus.fetch_complete), 32'd1);
    bus.rom_size = 32'd16;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(ROM_WORDS); i++) begin
      bus.rom_wr_en   = 1'b1;
      bus.rom_wr_addr = RW'(i);
      bus.rom_wr_data = (i < 4) ? prog[i] : $urandom;
      cycle();
    end
    bus.rom_wr_en = 1'b0;

    // Four-instruction program at full throughput
    for (int i = 0; i < 6; i++) begin
      bus.run         = tbl[i].run;
      bus.instr_ready = tbl[i].ready;
      cycle();
      chk("tbl_valid", 32'(bus.instr_valid), 32'(tbl[i].exp_valid));
      chk("tbl_instr", bus.instruction, tbl[i].exp_instr);
      chk("tbl_pc", bus.instr_pc, tbl[i].exp_pc);
      chk("tbl_occ", 32'(bus.occupancy), 32'(tbl[i].exp_occ));
      chk("tbl_fc", 32'(bus.fetch_complete), 32'(tbl[i].exp_fc));
    end

    // Raising rom_size resumes fetch; stall decode until the queue saturates
    bus.rom_size    = 32'h2000;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    chk("sat_occ", 32'(bus.occupancy), QD);
    chk("sat_head", bus.instr_pc, 32'd16);

    bus.instr_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      chk("thru_occ", 32'(bus.occupancy), QD);
      chk("thru_pc", bus.instr_pc, 32'(16 + 4 * k));
    end

    bus.run = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("drain_occ", 32'(bus.occupancy), 32'(QD - k));
    end

    bus.run = 1'b1;
    last_pc = 32'hffff_ffff;
    for (int i = 0; i < 400; i++) begin
      if (bus.instr_valid) last_pc = bus.instr_pc;
      cycle();
    end
    chk("limit_fc", 32'(bus.fetch_complete), 32'd1);
    chk("limit_last_pc", last_pc, 32'h3fc);

    // Asynchronous reset with five entries queued
    async_reset();
    bus.run         = 1'b1;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("pre_rst_occ", 32'(bus.occupancy), 32'd5);
    async_reset();
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_occ", 32'(bus.occupancy), 32'd0);
    cycle();
    chk("refetch_pc", bus.instr_pc, RESET_PC);
    chk("refetch_instr", bus.instruction, prog[0]);

    // Redirect with three entries queued
    async_reset();
    for (int i = 0; i < 3; i++) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000000a;
    bus.instr_ready    = 1'b1;
    cycle();
`ifdef IFQ_REDIRECT_EN
    chk("redir_occ", 32'(bus.occupancy), 32'd0);
    chk("redir_valid", 32'(bus.instr_valid), 32'd0);
`else
    chk("noredir_occ", 32'(bus.occupancy), 32'd3);
    chk("noredir_pc", bus.instr_pc, 32'd4);
`endif
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    cycle();
`ifdef IFQ_REDIRECT_EN
    chk("redir_target", bus.instr_pc, 32'd8);
    chk("redir_occ1", 32'(bus.occupancy), 32'd1);
`else
    chk("noredir_occ2", 32'(bus.occupancy), 32'd4);
`endif

    // Randomised traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 399) async_reset();
      bus.run         = ($urandom_range(0, 9) != 0);
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 5))
          0:       bus.rom_size = 32'h0;
          1:       bus.rom_size = 32'h10;
          2:       bus.rom_size = 32'($urandom_range(0, 300)) << 2;
          3:       bus.rom_size = 32'($urandom_range(0, 1200));
          4:       bus.rom_size = 32'h2000;
          default: bus.rom_size = $urandom;
        endcase
      end
      bus.rom_wr_en      = ($urandom_range(0, 7) == 0);
      bus.rom_wr_addr    = RW'($urandom);
      bus.rom_wr_data    = $urandom;
      bus.redirect_valid = ($urandom_range(0, 40) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom
                                                       : 32'($urandom_range(0, 1100));
      cycle();
    end

    quiet_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
